t1_mem_responder: RTL and testbench
===================================

# t1_mem_responder

Synthesizable responder for the physical-memory (t1) side of the multiport algorithm tops: it receives the write-port-A / read-port-B command bundle that an algorithm top drives, stores data per virtual bank with bit-granular write masking, and returns read data after a fixed `DELAY` cycles. It is the memory end of the t1 interface, used in block-level simulation, FPGA prototyping, and as the reference model for algorithm-top regressions. It clears its array after reset, then asserts `ready`, and reports collisions and protocol errors.

## Interface
- `NUMVBNK`, 2: independent banks; each has one write port A and one read port B.
- `NUMSROW`, 4096: rows per bank; need not be a power of two.
- `BITSROW`, 12: row address width; `2**BITSROW >= NUMSROW`.
- `PHYWDTH`, 128: bits per row.
- `DELAY`, 1: read latency in cycles, legal 1..4.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `t1_writeA`  in  NUMVBNK  per-bank write enable.
- `t1_addrA`  in  NUMVBNK*BITSROW  per-bank write row; bank b at bits [b*BITSROW +: BITSROW].
- `t1_dinA`  in  NUMVBNK*PHYWDTH  per-bank write data.
- `t1_bwA`  in  NUMVBNK*PHYWDTH  per-bit write mask; 1 = bit written.
- `t1_readB`  in  NUMVBNK  per-bank read enable.
- `t1_addrB`  in  NUMVBNK*BITSROW  per-bank read row.
- `t1_doutB`  out  NUMVBNK*PHYWDTH  per-bank read data.
- `t1_voutB`  out  NUMVBNK  per-bank read-data valid strobe.
- `ready`  out  1  array initialised; commands are accepted.
- `err_oor`  out  1  sticky: an access used a row >= NUMSROW.
- `err_early`  out  1  sticky: a command arrived while `ready`=0.
- `col_cnt`  out  8  count of same-bank, same-row read/write collisions; saturates at 255.

## Operation
- FSM: INIT -> RUN. `rst` low forces INIT asynchronously, with row counter 0.
- INIT: each cycle writes all-zero rows at the counter row in every bank in parallel, then increments. After row NUMSROW-1 the FSM moves to RUN. `ready` is 0 in INIT and 1 in RUN.
- Commands in INIT:
  - Any `t1_writeA` or `t1_readB` bit set is ignored.
  - `err_early` is set.
  - No `t1_voutB` pulse is generated.
- Write in RUN, `t1_writeA[b]`=1 and row < NUMSROW:
  - New row = (old & ~bw) | (din & bw).
  - bw=0 leaves the row unchanged.
- Read in RUN, `t1_readB[b]`=1 and row < NUMSROW: the row content is launched into a DELAY-deep per-bank pipeline.
- Out of range (row >= NUMSROW):
  - A write is dropped.
  - A read returns all zeros, still with `t1_voutB`.
  - `err_oor` is set.
- Collision (same bank, same cycle, both enables, equal in-range rows):
  - The read returns pre-write data.
  - The write completes.
  - `col_cnt` increments by 1 and saturates at 255.
  - Several banks colliding in one cycle add their count, still saturating.
- Banks are fully independent. No cross-bank interaction.
- `t1_doutB[b]` holds its last delivered value until the next read delivery. `t1_voutB[b]` pulses for one cycle.
- `err_oor` and `err_early` clear only on reset.

## Timing
- Reset values:
  - `ready`=0, `t1_doutB`=0, `t1_voutB`=0, `err_oor`=0, `err_early`=0, `col_cnt`=0.
  - Pipeline valids are 0. Array contents are undefined until INIT completes.
- `ready` rises at the clock edge that completes the last INIT row. It first reads 1 NUMSROW cycles after the first edge with `rst` high.
- Read issued in cycle N: `t1_doutB`/`t1_voutB` are updated at edge N+DELAY. Back-to-back reads give one result per cycle.
- Write in cycle N is visible to a read issued in cycle N+1 or later.
- Reset asserted mid-operation:
  - In-flight reads are discarded; no `t1_voutB` pulse.
  - All outputs return to reset values.
  - INIT restarts from row 0 on release.

## Test plan
- Reset/init, NUMVBNK=2, NUMSROW=12, BITSROW=4, PHYWDTH=16, DELAY=2: release `rst` -> `ready`=0 for 12 cycles then 1; a read of any row in either bank returns 0x0000.
- Masked write: bank1 row 5 din=0xFFFF bw=0xFFFF, then din=0x1234 bw=0x00FF, read row 5 -> `t1_doutB` bank1 = 0xFF34, `t1_voutB[1]` pulses exactly 2 cycles after the read.
- Collision: bank0 row 3 holds 0xAAAA; same cycle write 0x5555 bw=0xFFFF plus read row 3 -> read returns 0xAAAA, `col_cnt`=1; next-cycle read -> 0x5555. 300 collisions -> `col_cnt`=255.
- Out of range: write row 13 then read row 13 -> `t1_doutB`=0x0000 with valid, `err_oor`=1, rows 0..11 unchanged.
- Early command: pulse `t1_readB[0]` during INIT -> no valid pulse, `err_early`=1, INIT still completes at 12 cycles.
- Reset mid-read: issue a read, drop `rst` one cycle later -> no `t1_voutB`, outputs zero, `ready`=0, re-init to 12 cycles after release.

Source files
------------

// File: rtl/t1_mem_responder.sv
// t1_mem_responder
// Physical-memory end of the t1 interface. Each virtual bank has one masked
// write port (A) and one read port (B). Read data returns after a fixed DELAY
// cycles. After reset the array is cleared one row per cycle (all banks in
// parallel), and only then is `ready` raised.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   t1_writeA  per-bank write enable
//   t1_addrA   per-bank write row   (bank b at [b*BITSROW +: BITSROW])
//   t1_dinA    per-bank write data  (bank b at [b*PHYWDTH +: PHYWDTH])
//   t1_bwA     per-bank bit write mask, 1 = bit written
//   t1_readB   per-bank read enable
//   t1_addrB   per-bank read row
//   t1_doutB   per-bank read data, holds last delivered value
//   t1_voutB   per-bank one-cycle read-data valid
//   ready      array initialised, commands accepted
//   err_oor    sticky: access to row >= NUMSROW
//   err_early  sticky: command seen while not ready
//   col_cnt    saturating count of same-bank same-row read/write collisions
module t1_mem_responder #(
  parameter int unsigned NUMVBNK = 2,
  parameter int unsigned NUMSROW = 4096,
  parameter int unsigned BITSROW = 12,
  parameter int unsigned PHYWDTH = 128,
  parameter int unsigned DELAY   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUMVBNK-1:0]           t1_writeA,
  input  logic [NUMVBNK*BITSROW-1:0]   t1_addrA,
  input  logic [NUMVBNK*PHYWDTH-1:0]   t1_dinA,
  input  logic [NUMVBNK*PHYWDTH-1:0]   t1_bwA,
  input  logic [NUMVBNK-1:0]           t1_readB,
  input  logic [NUMVBNK*BITSROW-1:0]   t1_addrB,
  output logic [NUMVBNK*PHYWDTH-1:0]   t1_doutB,
  output logic [NUMVBNK-1:0]           t1_voutB,
  output logic                         ready,
  output logic                         err_oor,
  output logic                         err_early,
  output logic [7:0]                   col_cnt
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_run;
  logic [BITSROW-1:0]   r_init_row;
  logic                 w_init_last;

  logic [NUMVBNK-1:0]   w_col;
  logic [NUMVBNK-1:0]   w_oor;
  logic [15:0]          w_col_sum;
  logic [15:0]          w_col_tot;
  logic [7:0]           r_col_cnt;
  logic                 r_err_oor;
  logic                 r_err_early;

  assign w_init_last = (32'(r_init_row) == (NUMSROW - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_run = 1'b0;
    case (r_state)
      ST_RUN:  w_run = 1'b1;
      default: w_run = 1'b0;
    endcase
  end

  assign ready = w_run;

  // Init row counter; parked at 0 once running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_row <= '0;
    end else if (!w_run) begin
      r_init_row <= w_init_last ? '0 : r_init_row + 1'b1;
    end
  end

  // ---------------- per-bank storage and read pipeline ----------------
  for (genvar b = 0; b < NUMVBNK; b++) begin : g_bank
    logic [PHYWDTH-1:0] r_mem [NUMSROW];
    logic [BITSROW-1:0] w_wr_row;
    logic [BITSROW-1:0] w_rd_row;
    logic [PHYWDTH-1:0] w_din;
    logic [PHYWDTH-1:0] w_bw;
    logic               w_wr_inr;
    logic               w_rd_inr;
    logic               w_wr_ok;
    logic               w_rd_en;
    logic               r_pv [DELAY];
    logic [PHYWDTH-1:0] r_pd [DELAY];

    assign w_wr_row = t1_addrA[b*BITSROW +: BITSROW];
    assign w_rd_row = t1_addrB[b*BITSROW +: BITSROW];
    assign w_din    = t1_dinA[b*PHYWDTH +: PHYWDTH];
    assign w_bw     = t1_bwA[b*PHYWDTH +: PHYWDTH];
    assign w_wr_inr = (32'(w_wr_row) < NUMSROW);
    assign w_rd_inr = (32'(w_rd_row) < NUMSROW);
    assign w_wr_ok  = w_run & t1_writeA[b] & w_wr_inr;
    assign w_rd_en  = w_run & t1_readB[b];

    assign w_col[b] = w_wr_ok & w_rd_en & w_rd_inr & (w_wr_row == w_rd_row);
    assign w_oor[b] = w_run & ((t1_writeA[b] & ~w_wr_inr) | (t1_readB[b] & ~w_rd_inr));

    // Array is not reset; INIT clears it. A colliding read sees the old row
    // because the write lands at the same edge the read is sampled.
    always_ff @(posedge clk) begin
      if (!w_run) begin
        r_mem[r_init_row] <= '0;
      end else if (w_wr_ok) begin
        r_mem[w_wr_row] <= (r_mem[w_wr_row] & ~w_bw) | (w_din & w_bw);
      end
    end

    // Each stage loads data only behind a valid, so the last stage doubles
    // as the hold register for t1_doutB.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned k = 0; k < DELAY; k++) begin
          r_pv[k] <= 1'b0;
          r_pd[k] <= '0;
        end
      end else begin
        r_pv[0] <= w_rd_en;
        if (w_rd_en) begin
          r_pd[0] <= w_rd_inr ? r_mem[w_rd_row] : '0;
        end
        for (int unsigned k = 1; k < DELAY; k++) begin
          r_pv[k] <= r_pv[k-1];
          if (r_pv[k-1]) begin
            r_pd[k] <= r_pd[k-1];
          end
        end
      end
    end

    assign t1_doutB[b*PHYWDTH +: PHYWDTH] = r_pd[DELAY-1];
    assign t1_voutB[b]                    = r_pv[DELAY-1];
  end

  // ---------------- status ----------------
  always_comb begin
    w_col_sum = '0;
    for (int unsigned b = 0; b < NUMVBNK; b++) begin
      w_col_sum = w_col_sum + {15'b0, w_col[b]};
    end
    w_col_tot = {8'b0, r_col_cnt} + w_col_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_cnt   <= '0;
      r_err_oor   <= 1'b0;
      r_err_early <= 1'b0;
    end else begin
      r_col_cnt <= (w_col_tot > 16'd255) ? 8'hFF : w_col_tot[7:0];
      if (|w_oor) begin
        r_err_oor <= 1'b1;
      end
      if (!w_run && (|t1_writeA || |t1_readB)) begin
        r_err_early <= 1'b1;
      end
    end
  end

  assign col_cnt   = r_col_cnt;
  assign err_oor   = r_err_oor;
  assign err_early = r_err_early;

endmodule

// File: tb/tb_t1_mem_responder.sv
module tb_t1_mem_responder;
  localparam int unsigned NB = 2;
  localparam int unsigned NR = 12;
  localparam int unsigned BR = 4;
  localparam int unsigned PW = 16;
  localparam int unsigned DL = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     t1_writeA;
  logic [NB*BR-1:0]  t1_addrA;
  logic [NB*PW-1:0]  t1_dinA;
  logic [NB*PW-1:0]  t1_bwA;
  logic [NB-1:0]     t1_readB;
  logic [NB*BR-1:0]  t1_addrB;
  logic [NB*PW-1:0]  t1_doutB;
  logic [NB-1:0]     t1_voutB;
  logic              ready;
  logic              err_oor;
  logic              err_early;
  logic [7:0]        col_cnt;

  int n_vec = 0;
  int n_err = 0;

  t1_mem_responder #(
    .NUMVBNK(NB), .NUMSROW(NR), .BITSROW(BR), .PHYWDTH(PW), .DELAY(DL)
  ) dut (
    .clk(clk), .rst(rst),
    .t1_writeA(t1_writeA), .t1_addrA(t1_addrA), .t1_dinA(t1_dinA), .t1_bwA(t1_bwA),
    .t1_readB(t1_readB), .t1_addrB(t1_addrB),
    .t1_doutB(t1_doutB), .t1_voutB(t1_voutB),
    .ready(ready), .err_oor(err_oor), .err_early(err_early), .col_cnt(col_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    t1_writeA = '0;
    t1_readB  = '0;
  endtask

  task automatic wr(input int b, input int row, input logic [15:0] d, input logic [15:0] bw);
    t1_writeA[b]         = 1'b1;
    t1_addrA[b*BR +: BR] = row[BR-1:0];
    t1_dinA[b*PW +: PW]  = d;
    t1_bwA[b*PW +: PW]   = bw;
  endtask

  task automatic rd(input int b, input int row);
    t1_readB[b]          = 1'b1;
    t1_addrB[b*BR +: BR] = row[BR-1:0];
  endtask

  // Single read, data/valid expected exactly DL cycles later.
  task automatic read_chk(input string tag, input int b, input int row, input logic [15:0] exp);
    rd(b, row);
    tick();
    idle();
    chk({tag, "_vout_early"}, 32'(t1_voutB[b]), 32'd0);
    tick();
    chk({tag, "_vout"}, 32'(t1_voutB[b]), 32'd1);
    chk({tag, "_dout"}, 32'(t1_doutB[b*PW +: PW]), 32'(exp));
    tick();
    chk({tag, "_vout_off"}, 32'(t1_voutB[b]), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_dout"}, t1_doutB, 32'd0);
    chk({tag, "_vout"}, 32'(t1_voutB), 32'd0);
    chk({tag, "_err_oor"}, 32'(err_oor), 32'd0);
    chk({tag, "_err_early"}, 32'(err_early), 32'd0);
    chk({tag, "_col_cnt"}, 32'(col_cnt), 32'd0);
  endtask

  // Release reset and step through INIT; optionally pulse a read mid-INIT.
  task automatic init_seq(input string tag, input bit early);
    rst = 1'b1;
    for (int k = 1; k <= int'(NR); k++) begin
      if (early && k == 3) rd(0, 2);
      tick();
      idle();
      chk($sformatf("%s_ready_c%0d", tag, k), 32'(ready), (k == int'(NR)) ? 32'd1 : 32'd0);
      chk($sformatf("%s_vout_c%0d", tag, k), 32'(t1_voutB), 32'd0);
    end
    tick();
    chk({tag, "_vout_after"}, 32'(t1_voutB), 32'd0);
    chk({tag, "_err_early"}, 32'(err_early), early ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    t1_writeA = '0;
    t1_addrA  = '0;
    t1_dinA   = '0;
    t1_bwA    = '0;
    t1_readB  = '0;
    t1_addrB  = '0;

    // Reset state and clean initialisation
    tick();
    tick();
    check_reset_outputs("rst");
    init_seq("init", 1'b0);

    // Freshly cleared array
    read_chk("clr_b0r0", 0, 0, 16'h0000);
    read_chk("clr_b1r11", 1, 11, 16'h0000);
    read_chk("clr_b0r7", 0, 7, 16'h0000);

    // Masked write
    wr(1, 5, 16'hFFFF, 16'hFFFF);
    tick();
    wr(1, 5, 16'h1234, 16'h00FF);
    tick();
    idle();
    read_chk("mask_b1r5", 1, 5, 16'hFF34);
    read_chk("mask_b0r5", 0, 5, 16'h0000);

    // Last in-range row
    wr(0, 11, 16'h0F0F, 16'hFFFF);
    tick();
    idle();
    read_chk("last_b0r11", 0, 11, 16'h0F0F);

    // Collision: read sees pre-write data
    wr(0, 3, 16'hAAAA, 16'hFFFF);
    tick();
    chk("col_none", 32'(col_cnt), 32'd0);
    wr(0, 3, 16'h5555, 16'hFFFF);
    rd(0, 3);
    tick();
    idle();
    chk("col_cnt1", 32'(col_cnt), 32'd1);
    tick();
    chk("col_vout", 32'(t1_voutB[0]), 32'd1);
    chk("col_dout", 32'(t1_doutB[15:0]), 32'h0000AAAA);
    read_chk("col_after", 0, 3, 16'h5555);

    // Zero mask leaves row alone
    wr(0, 3, 16'h0000, 16'h0000);
    tick();
    idle();
    read_chk("bw0_b0r3", 0, 3, 16'h5555);

    // Out of range
    chk("oor_clear", 32'(err_oor), 32'd0);
    wr(1, 13, 16'hBEEF, 16'hFFFF);
    tick();
    idle();
    chk("oor_set", 32'(err_oor), 32'd1);
    read_chk("oor_rd13", 1, 13, 16'h0000);
    read_chk("oor_rd12", 0, 12, 16'h0000);
    for (int r = 0; r < int'(NR); r++) begin
      read_chk($sformatf("oor_keep_r%0d", r), 1, r, (r == 5) ? 16'hFF34 : 16'h0000);
    end
    chk("oor_sticky", 32'(err_oor), 32'd1);

    // Both banks collide in one cycle: +2
    wr(0, 3, 16'h5555, 16'hFFFF);
    rd(0, 3);
    wr(1, 3, 16'h1111, 16'hFFFF);
    rd(1, 3);
    tick();
    idle();
    chk("col_dual", 32'(col_cnt), 32'd3);
    tick();
    chk("col_dual_b1", 32'(t1_doutB[31:16]), 32'h00000000);
    tick();
    read_chk("col_dual_b1_after", 1, 3, 16'h1111);

    // Saturation: 3 so far, 252 more reach 255, 45 more stay there
    for (int i = 0; i < 252; i++) begin
      wr(0, 3, 16'h5555, 16'hFFFF);
      rd(0, 3);
      tick();
    end
    idle();
    chk("col_255", 32'(col_cnt), 32'd255);
    for (int i = 0; i < 45; i++) begin
      wr(0, 3, 16'h5555, 16'hFFFF);
      rd(0, 3);
      tick();
    end
    idle();
    chk("col_sat", 32'(col_cnt), 32'd255);
    tick();
    tick();
    tick();

    // Reset during an in-flight read, then re-init with an early command
    rd(0, 11);
    tick();
    idle();
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    chk("midrst_vout_c1", 32'(t1_voutB), 32'd0);
    tick();
    chk("midrst_vout_c2", 32'(t1_voutB), 32'd0);
    init_seq("reinit", 1'b1);
    read_chk("reinit_b0r11", 0, 11, 16'h0000);
    chk("reinit_oor", 32'(err_oor), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
